// File: rtl/io_supply_sequencer.sv
// io_supply_sequencer: core-side power sequencer for one VDDIO-fed IO ring
// segment. Synchronises and debounces the supply-good flag, walks the pads
// through retention release and isolation release, and flags a sticky fault
// if the supply collapses while the ring is active.
module io_supply_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RET_DELAY       = 8,
  parameter int ISO_DELAY       = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddio_ok_i,
  input  logic       en_i,
  input  logic       fault_clr_i,
  output logic       io_ret_o,
  output logic       io_iso_o,
  output logic       io_ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_RELRET   = 3'd2,
    S_RELISO   = 3'd3,
    S_READY    = 3'd4,
    S_SHUTDOWN = 3'd5
  } state_t;

  // Terminal counts: a timed state lasts exactly its parameter in cycles.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_DELAY - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             sync1, vddio_s;
  logic             fault_set;

  // Two-flop synchroniser; the only consumer of the asynchronous supply flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      vddio_s <= 1'b0;
    end else begin
      sync1   <= vddio_ok_i;
      vddio_s <= sync1;
    end
  end

  // Next-state selection; supply loss in any powered state beats enable.
  always_comb begin
    state_nx  = state;
    fault_set = 1'b0;
    if ((state == S_RELRET || state == S_RELISO || state == S_READY ||
         state == S_SHUTDOWN) && !vddio_s) begin
      state_nx  = S_OFF;
      fault_set = 1'b1;
    end else begin
      case (state)
        S_OFF:      if (en_i && vddio_s && !fault_o) state_nx = S_DEBOUNCE;
        S_DEBOUNCE: if (!vddio_s || !en_i)          state_nx = S_OFF;
                    else if (cnt == DB_LAST)        state_nx = S_RELRET;
        S_RELRET:   if (cnt == RET_LAST)            state_nx = S_RELISO;
                    else if (!en_i)                 state_nx = S_SHUTDOWN;
        S_RELISO:   if (cnt == ISO_LAST)            state_nx = S_READY;
                    else if (!en_i)                 state_nx = S_SHUTDOWN;
        S_READY:    if (!en_i)                      state_nx = S_SHUTDOWN;
        S_SHUTDOWN: if (cnt == ISO_LAST)            state_nx = S_OFF;
        default:                                    state_nx = S_OFF;
      endcase
    end
  end

  // State, shared delay counter, sticky fault and pad controls decoded from
  // next state so every output moves on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      cnt        <= '0;
      fault_o    <= 1'b0;
      io_ret_o   <= 1'b1;
      io_iso_o   <= 1'b1;
      io_ready_o <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= (state_nx != state) ? '0 : cnt + 1'b1;
      // A new loss outranks a coincident clear.
      fault_o <= fault_set | (fault_o & ~fault_clr_i);
      io_ret_o   <= (state_nx == S_OFF) || (state_nx == S_DEBOUNCE);
      io_iso_o   <= (state_nx != S_RELISO) && (state_nx != S_READY);
      io_ready_o <= (state_nx == S_READY);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_io_supply_sequencer.sv
// tb_io_supply_sequencer: directed power sequencing scenarios followed by a
// randomized soak, all shadowed by a cycle-level behavioural model.
module tb_io_supply_sequencer;

  logic       clk = 1'b0;
  logic       rst, vddio_ok_i, en_i, fault_clr_i;
  logic       io_ret_o, io_iso_o, io_ready_o, fault_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  io_supply_sequencer #(
    .DEBOUNCE_CYCLES(16), .RET_DELAY(8), .ISO_DELAY(8), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .vddio_ok_i(vddio_ok_i), .en_i(en_i),
    .fault_clr_i(fault_clr_i), .io_ret_o(io_ret_o), .io_iso_o(io_iso_o),
    .io_ready_o(io_ready_o), .fault_o(fault_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {state, ret, iso, ready, fault}
  function automatic logic [6:0] dv();
    return {state_o, io_ret_o, io_iso_o, io_ready_o, fault_o};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_after(input int e);
    while (cyc < base + e + 1) @(negedge clk);
  endtask

  // Behavioural model: phases with fixed durations measured from entry time.
  int         dur [6] = '{0, 16, 8, 8, 0, 8};
  logic [5:0] ret_t   = 6'b000011;
  logic [5:0] iso_t   = 6'b100111;
  logic [5:0] rdy_t   = 6'b010000;
  int         m_st = 0, m_ent = 0;
  bit         m_f = 0, sh0 = 0, sh1 = 0;

  always @(posedge clk) begin
    bit vs, full, set, in_rst, in_en, in_clr, in_ok;
    int nx;
    in_rst = rst; in_en = en_i; in_clr = fault_clr_i; in_ok = vddio_ok_i;
    vs = sh1;
    cyc++;
    if (in_rst) begin
      m_st = 0; m_f = 0; sh0 = 0; sh1 = 0; m_ent = cyc;
    end else begin
      full = (dur[m_st] != 0) && (cyc - m_ent == dur[m_st]);
      nx = m_st; set = 0;
      if (m_st >= 2 && !vs) begin
        nx = 0; set = 1;
      end else begin
        case (m_st)
          0: if (in_en && vs && !m_f) nx = 1;
          1: if (!vs || !in_en) nx = 0; else if (full) nx = 2;
          2: if (full) nx = 3; else if (!in_en) nx = 5;
          3: if (full) nx = 4; else if (!in_en) nx = 5;
          4: if (!in_en) nx = 5;
          5: if (full) nx = 0;
          default: nx = 0;
        endcase
      end
      m_f = set || (m_f && !in_clr);
      if (nx != m_st) m_ent = cyc;
      m_st = nx;
      sh1 = sh0; sh0 = in_ok;
    end
    #1;
    chk("model", dv(), {3'(m_st), ret_t[m_st], iso_t[m_st], rdy_t[m_st], m_f});
  end

  initial begin
    rst = 1; vddio_ok_i = 0; en_i = 0; fault_clr_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_vals", dv(), 7'b000_1100);

    // Power-up latency
    rst = 0; en_i = 1; vddio_ok_i = 1; base = cyc;
    wait_after(1);  chk("pu_e1_off",     dv(), 7'b000_1100);
    wait_after(2);  chk("pu_e2_deb",     dv(), 7'b001_1100);
    wait_after(17); chk("pu_e17_deb",    dv(), 7'b001_1100);
    wait_after(18); chk("pu_e18_relret", dv(), 7'b010_0100);
    wait_after(26); chk("pu_e26_reliso", dv(), 7'b011_0000);
    wait_after(34); chk("pu_e34_ready",  dv(), 7'b100_0010);

    // Supply loss in READY, then fault holds OFF
    wait_after(40); vddio_ok_i = 0; base = cyc;
    wait_after(1); chk("loss_e1", dv(), 7'b100_0010);
    wait_after(2); chk("loss_e2", dv(), 7'b000_1101);
    vddio_ok_i = 1; base = cyc;
    wait_after(50); chk("fault_hold", dv(), 7'b000_1101);

    // Clear restarts the sequence
    fault_clr_i = 1; base = cyc; wait_after(0); fault_clr_i = 0;
    chk("clr_e0",   dv(), 7'b000_1100);
    wait_after(1);  chk("clr_e1_deb",  dv(), 7'b001_1100);
    wait_after(33); chk("clr_ready",   dv(), 7'b100_0010);

    // Clear coincident with a new loss: set wins
    vddio_ok_i = 0; base = cyc;
    wait_after(1); fault_clr_i = 1;
    wait_after(2); fault_clr_i = 0;
    chk("race_set_wins", dv(), 7'b000_1101);
    vddio_ok_i = 1;
    wait_after(7); chk("race_hold", dv(), 7'b000_1101);
    fault_clr_i = 1; base = cyc; wait_after(0); fault_clr_i = 0;
    wait_after(33); chk("race_ready", dv(), 7'b100_0010);

    // Orderly shutdown; re-enable mid-shutdown is ignored
    en_i = 0; base = cyc;
    wait_after(0); chk("sd_e0", dv(), 7'b101_0100);
    wait_after(2); en_i = 1;
    wait_after(7); chk("sd_e7", dv(), 7'b101_0100);
    wait_after(8); chk("sd_e8", dv(), 7'b000_1100);

    // Debounce glitch: DEBOUNCE entered at edge 9
    wait_after(19); vddio_ok_i = 0;
    wait_after(20); vddio_ok_i = 1;
    wait_after(22); chk("gl_off",    dv(), 7'b000_1100);
    wait_after(54); chk("gl_reliso", dv(), 7'b011_0000);
    wait_after(55); chk("gl_ready",  dv(), 7'b100_0010);

    // en drop and supply drop together in RELISO
    en_i = 0; base = cyc;
    wait_after(10); en_i = 1; base = cyc;
    wait_after(25); en_i = 0; vddio_ok_i = 0;
    wait_after(26); chk("sim_sd",    dv(), 7'b101_0100);
    wait_after(28); chk("sim_fault", dv(), 7'b000_1101);

    // Reset clears the fault, then reset mid-RELRET
    rst = 1; base = cyc; wait_after(0);
    chk("rst_fault", dv(), 7'b000_1100);
    rst = 0; en_i = 1; vddio_ok_i = 1; base = cyc;
    wait_after(20); chk("rr_before_rst", dv(), 7'b010_0100);
    rst = 1; base = cyc; wait_after(0);
    chk("rst_relret", dv(), 7'b000_1100);
    rst = 0;

    // Randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(99) < 3) vddio_ok_i = ~vddio_ok_i;
      if ($urandom_range(99) < 2) en_i = ~en_i;
      fault_clr_i = ($urandom_range(99) < 4);
      rst = ($urandom_range(999) < 3);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
